osd_spi_master: RTL and testbench
=================================

Name: osd_spi_master

Overview:
- On-FPGA SPI initiator for the OSD command channel. Drives SPI_SCK / SPI_SS3 / SPI_DI toward the OSD's SPI receiver, so core-side logic can raise or lower the OSD and rewrite OSD lines without the io controller.
- Accepts one command at a time through a valid/ready port.
- For line writes, fetches the 256-byte payload through a synchronous read port.
- Emits exactly the framing the OSD receiver decodes: command byte first, then payload bytes, MSB first, SS3 low for the whole transaction.

Parameters:
- CLK_DIV, 4: clk_sys cycles per SCK half-period; legal range 1..255.
- LINE_BYTES, 256: payload bytes per write command; legal range 1..256.

Ports:
- clk_sys  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE; a command is accepted on a cycle with cmd_valid && cmd_ready.
- cmd_type  in  2  0 = OSD disable (byte 0x40), 1 = OSD enable (0x41), 2 = write line (0x20 | cmd_line), 3 = reserved.
- cmd_line  in  3  line address, used only for type 2.
- rd_addr  out  8  index of the next payload byte.
- rd_data  in  8  payload byte for rd_addr; must be valid by 2 clk_sys cycles after rd_addr changes.
- busy  out  1  high from acceptance until return to IDLE.
- done  out  1  one-cycle pulse at transaction end.
- SPI_SCK  out  1  serial clock; idles low.
- SPI_SS3  out  1  chip select, active low; idles high.
- SPI_DI  out  1  serial data toward the OSD.

Behaviour:
- Reset (asynchronous, any state, including mid-transfer):
  - Outputs: SPI_SS3 = 1, SPI_SCK = 0, SPI_DI = 0, busy = 0, done = 0, rd_addr = 0.
  - FSM goes to IDLE. cmd_ready = 1 from the first clk_sys edge after reset deasserts.
  - A partial transfer is abandoned. The OSD receiver resynchronises on the SS3 rising edge.
- FSM states: IDLE, SHIFT, HOLD, GAP.
- IDLE:
  - cmd_ready = 1, busy = 0.
  - On acceptance: latch the command byte, set rd_addr = 0, byte counter = 0, bit counter = 7.
  - Next cycle: SS3 = 0, SCK = 0, DI = command bit 7, busy = 1. Go to SHIFT.
- Type 3 is accepted but causes no SPI activity: done pulses the cycle after acceptance and the FSM stays in IDLE.
- SHIFT, per-bit timing (bit period = 2*CLK_DIV cycles):
  - DI changes only while SCK is low.
  - SCK low for CLK_DIV cycles, then high for CLK_DIV cycles. The receiver samples on the SCK rising edge.
  - On each SCK falling edge: shift out the next bit (MSB first) and decrement the bit counter.
- SHIFT, byte boundaries:
  - After bit 0 of a byte, on the falling edge, if more bytes remain: load the shift register from rd_data, place its bit 7 on DI, increment rd_addr (8-bit, wraps 255 -> 0), and set the bit counter to 7.
  - Bytes sent: type 0/1 = 1 byte, type 2 = 1 + LINE_BYTES bytes.
  - The byte counter is 9 bits; the last byte is detected when the count reaches the total.
  - Gaps: no extra SCK gap between bytes; no SCK pulses before the first bit or after the last bit.
- HOLD: after the falling edge of the final bit, keep SS3 = 0, SCK = 0 for CLK_DIV cycles, then drive SS3 = 1 and pulse done. Go to GAP.
- GAP: SS3 high for 2*CLK_DIV cycles (this satisfies the receiver reset window), then go to IDLE.
- busy falls on the GAP -> IDLE cycle.
- cmd_valid outside IDLE is ignored and never queued.
- Transaction lengths:
  - Type 0/1: 16*CLK_DIV cycles with SS3 low (SCK phases), plus CLK_DIV cycles of HOLD.
  - Type 2: (1 + LINE_BYTES)*16*CLK_DIV cycles with SS3 low, plus CLK_DIV cycles of HOLD.
- rd_data is sampled only at byte-load instants and may change freely otherwise.

Test Plan:
- Enable: CLK_DIV = 4, type 1 → 8 SCK rising edges, DI sampled 0,1,0,0,0,0,0,1 (0x41). SS3 low for 68 cycles. done 1 cycle. cmd_ready high again 8 cycles later.
- Disable then enable back-to-back: cmd_valid held high → two separate SS3 frames carrying 0x40 then 0x41, ≥8 cycles SS3 high between them. A bench receiver model shows osd_enable = 1 at the end.
- Write line 5, rd_data = rd_addr ^ 0xA5 → first byte 0x25, then 256 bytes 0xA5, 0xA4, ... 0x5A. rd_addr ends at 0 (wrapped). Receiver model buffer[0x500 + i] = i ^ 0xA5 for all i.
- CLK_DIV = 1, LINE_BYTES = 4, type 2 line 7 → SCK toggles every cycle. Exactly 40 rising edges. Command byte 0x27, payload correct.
- Reset asserted mid-payload (byte 100, bit 3) → SS3 = 1, SCK = 0, DI = 0 immediately, with no clock edge needed. A new enable command after reset produces a clean 0x41 frame.
- Type 3 and cmd_valid while busy → no SCK/SS3 activity for type 3 (done pulse only). The mid-transfer request is dropped and does not alter the in-flight frame.

Source files
------------

// File: rtl/osd_spi_master.sv
`timescale 1ns/1ps
// osd_spi_master
// SPI initiator for the OSD command channel. It takes one command at a time
// and sends a command byte, followed by line payload bytes for line writes.
// Bytes go out MSB first. SPI_SS3 stays low for the whole transaction.
//
// Ports
//   clk_sys, reset        : system clock (rising edge); async active-high reset
//   cmd_valid / cmd_ready : command handshake; cmd_ready is high only in IDLE
//   cmd_type, cmd_line    : 0 = disable 0x40, 1 = enable 0x41,
//                           2 = write line (0x20 | line), 3 = no-op
//   rd_addr / rd_data     : payload fetch port; data is due 2 cycles after
//                           the address changes
//   busy, done            : transaction in flight; end-of-transaction pulse
//   SPI_SCK/SS3/DI        : serial clock (idles low), select (active low), data
module osd_spi_master #(
  parameter int unsigned CLK_DIV    = 4,   // clk_sys cycles per SCK half-period, 1..255
  parameter int unsigned LINE_BYTES = 256  // payload bytes per line write, 1..256
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_type,
  input  logic [2:0] cmd_line,
  output logic [7:0] rd_addr,
  input  logic [7:0] rd_data,
  output logic       busy,
  output logic       done,
  output logic       SPI_SCK,
  output logic       SPI_SS3,
  output logic       SPI_DI
);

  localparam int unsigned CNT_W = 9;
  localparam int unsigned BYTE_CNT_W = 9;

  // Last count of an SCK half-period / HOLD phase, and of the GAP phase.
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(2 * CLK_DIV - 1);

  // Total number of bytes in a line write: command byte plus payload.
  localparam logic [BYTE_CNT_W-1:0] WRITE_TOTAL = BYTE_CNT_W'(LINE_BYTES + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_HOLD,
    S_GAP
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    sck_q, sck_d;
  logic                    ss3_q, ss3_d;
  logic                    di_q, di_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    ready_q, ready_d;
  logic [7:0]              rd_addr_q, rd_addr_d;
  logic [7:0]              shreg_q, shreg_d;
  logic [2:0]              bit_cnt_q, bit_cnt_d;
  logic [BYTE_CNT_W-1:0]   byte_cnt_q, byte_cnt_d;
  logic [BYTE_CNT_W-1:0]   total_q, total_d;

  logic [7:0]              cmd_byte_c;
  logic [BYTE_CNT_W-1:0]   cmd_total_c;
  logic                    last_byte_c;

  // Command byte and transaction length for the offered command.
  always_comb begin
    cmd_byte_c  = 8'h00;
    cmd_total_c = BYTE_CNT_W'(1);
    case (cmd_type)
      2'd0:    cmd_byte_c = 8'h40;
      2'd1:    cmd_byte_c = 8'h41;
      2'd2: begin
        cmd_byte_c  = {5'b00100, cmd_line};
        cmd_total_c = WRITE_TOTAL;
      end
      default: cmd_byte_c = 8'h00;
    endcase
  end

  // The byte now being shifted is the final one of the transaction.
  assign last_byte_c = ((byte_cnt_q + BYTE_CNT_W'(1)) == total_q);

  // State and datapath registers.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      sck_q      <= 1'b0;
      ss3_q      <= 1'b1;
      di_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ready_q    <= 1'b0;
      rd_addr_q  <= '0;
      shreg_q    <= '0;
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
      total_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sck_q      <= sck_d;
      ss3_q      <= ss3_d;
      di_q       <= di_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ready_q    <= ready_d;
      rd_addr_q  <= rd_addr_d;
      shreg_q    <= shreg_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      total_q    <= total_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sck_d      = sck_q;
    ss3_d      = ss3_q;
    di_d       = di_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    ready_d    = ready_q;
    rd_addr_d  = rd_addr_q;
    shreg_d    = shreg_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    total_d    = total_q;

    case (state_q)
      S_IDLE: begin
        ready_d = 1'b1;
        busy_d  = 1'b0;
        sck_d   = 1'b0;
        ss3_d   = 1'b1;
        di_d    = 1'b0;
        cnt_d   = '0;
        // ready_q gates acceptance so the first cycle after reset is ignored.
        if (cmd_valid && ready_q) begin
          if (cmd_type == 2'd3) begin
            done_d = 1'b1;
          end else begin
            state_d    = S_SHIFT;
            ready_d    = 1'b0;
            busy_d     = 1'b1;
            ss3_d      = 1'b0;
            shreg_d    = cmd_byte_c;
            di_d       = cmd_byte_c[7];
            bit_cnt_d  = 3'd7;
            byte_cnt_d = '0;
            total_d    = cmd_total_c;
            rd_addr_d  = '0;
          end
        end
      end

      S_SHIFT: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d = '0;
          if (!sck_q) begin
            sck_d = 1'b1;
          end else begin
            // Falling edge: DI only moves here, while SCK is low.
            sck_d = 1'b0;
            if (bit_cnt_q != 3'd0) begin
              shreg_d   = {shreg_q[6:0], 1'b0};
              di_d      = shreg_q[6];
              bit_cnt_d = bit_cnt_q - 3'd1;
            end else if (last_byte_c) begin
              state_d = S_HOLD;
              di_d    = 1'b0;
            end else begin
              // Next payload byte follows with no SCK gap.
              shreg_d    = rd_data;
              di_d       = rd_data[7];
              rd_addr_d  = rd_addr_q + 8'd1;
              byte_cnt_d = byte_cnt_q + BYTE_CNT_W'(1);
              bit_cnt_d  = 3'd7;
            end
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_HOLD: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d   = '0;
          ss3_d   = 1'b1;
          done_d  = 1'b1;
          state_d = S_GAP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_GAP: begin
        // Select stays high long enough for the receiver to resynchronise.
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          busy_d  = 1'b0;
          ready_d = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign cmd_ready = ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign rd_addr   = rd_addr_q;
  assign SPI_SCK   = sck_q;
  assign SPI_SS3   = ss3_q;
  assign SPI_DI    = di_q;

endmodule

// File: tb/tb_osd_spi_master.sv
`timescale 1ns/1ps
// Bench for osd_spi_master: a CLK_DIV=4 / 256-byte instance and a CLK_DIV=1 /
// 4-byte instance. An SPI receiver model decodes frames and checks them
// against queued expected bytes and frame shapes.
module tb_osd_spi_master;

  localparam int LIMIT = 40000;

  typedef struct {
    int nbytes;
    int bits;
    int rises;
    int low;
  } frame_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_a, cmd_valid_a, cmd_ready_a, busy_a, done_a, sck_a, ss3_a, di_a;
  logic [1:0] cmd_type_a;
  logic [2:0] cmd_line_a;
  logic [7:0] rd_addr_a, rd_data_a;
  logic       reset_b, cmd_valid_b, cmd_ready_b, busy_b, done_b, sck_b, ss3_b, di_b;
  logic [1:0] cmd_type_b;
  logic [2:0] cmd_line_b;
  logic [7:0] rd_addr_b, rd_data_b;

  osd_spi_master dut_a (
    .clk_sys(clk), .reset(reset_a), .cmd_valid(cmd_valid_a), .cmd_ready(cmd_ready_a),
    .cmd_type(cmd_type_a), .cmd_line(cmd_line_a), .rd_addr(rd_addr_a), .rd_data(rd_data_a),
    .busy(busy_a), .done(done_a), .SPI_SCK(sck_a), .SPI_SS3(ss3_a), .SPI_DI(di_a)
  );

  osd_spi_master #(.CLK_DIV(1), .LINE_BYTES(4)) dut_b (
    .clk_sys(clk), .reset(reset_b), .cmd_valid(cmd_valid_b), .cmd_ready(cmd_ready_b),
    .cmd_type(cmd_type_b), .cmd_line(cmd_line_b), .rd_addr(rd_addr_b), .rd_data(rd_data_b),
    .busy(busy_b), .done(done_b), .SPI_SCK(sck_b), .SPI_SS3(ss3_b), .SPI_DI(di_b)
  );

  // Payload memories with one cycle of read latency.
  always @(posedge clk) begin
    rd_data_a <= rd_addr_a ^ 8'hA5;
    rd_data_b <= rd_addr_b ^ 8'hA5;
  end

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_bytes [$];
  frame_t     exp_frames [$];

  // Receiver model state, one slot per DUT.
  logic       prev_sck [2] = '{1'b0, 1'b0};
  logic       prev_ss3 [2] = '{1'b1, 1'b1};
  logic       prev_di  [2] = '{1'b0, 1'b0};
  logic [7:0] sh       [2];
  int nbits [2], nbytes [2], rises [2], low [2], high_cnt [2], last_gap [2];
  int frames [2], total_rises [2], osd_en [2];
  logic [7:0] fbuf  [2][0:259];
  logic [7:0] rxbuf [0:2047];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_frame(input int nb, input int bits, input int r, input int lw);
    frame_t f;
    f.nbytes = nb; f.bits = bits; f.rises = r; f.low = lw;
    exp_frames.push_back(f);
  endtask

  // Receiver: one step per clk_sys falling edge.
  task automatic mon_step(input int id, input logic sck, input logic ss3, input logic di);
    logic [7:0] b;
    logic [7:0] cmd;
    frame_t f;
    int idx;
    if (prev_ss3[id] && !ss3) begin
      nbytes[id] = 0; nbits[id] = 0; rises[id] = 0; low[id] = 0;
      last_gap[id] = high_cnt[id];
    end
    if (!prev_sck[id] && sck) total_rises[id]++;
    if (!prev_ss3[id] && ss3) begin
      frames[id]++;
      if (exp_frames.size() == 0) begin
        checks++; errors++;
        $display("FAIL frame: unexpected frame on dut %0d", id);
      end else begin
        f = exp_frames.pop_front();
        check("frame bytes", nbytes[id], f.nbytes);
        check("frame partial bits", nbits[id], f.bits);
        check("frame sck rises", rises[id], f.rises);
        if (f.low != 0) check("frame ss3 low cycles", low[id], f.low);
      end
      // Only complete frames take effect in the receiver.
      if (nbits[id] == 0 && nbytes[id] > 0) begin
        cmd = fbuf[id][0];
        if (cmd == 8'h40) osd_en[id] = 0;
        else if (cmd == 8'h41) osd_en[id] = 1;
        else if (cmd[7:3] == 5'b00100) begin
          for (int i = 1; i < nbytes[id] && i < 260; i++) begin
            idx = int'(cmd[2:0]) * 256 + i - 1;
            if (idx < 2048) rxbuf[idx] = fbuf[id][i];
          end
        end
      end
      high_cnt[id] = 0;
    end
    if (!ss3) begin
      low[id]++;
      if (prev_sck[id] && sck) check("di stable while sck high", di, prev_di[id]);
      if (!prev_sck[id] && sck) begin
        rises[id]++;
        b = {sh[id][6:0], di};
        sh[id] = b;
        nbits[id]++;
        if (nbits[id] == 8) begin
          nbits[id] = 0;
          if (nbytes[id] < 260) fbuf[id][nbytes[id]] = b;
          nbytes[id]++;
          if (exp_bytes.size() == 0) begin
            checks++; errors++;
            $display("FAIL spi byte: unexpected byte 0x%02h on dut %0d", b, id);
          end else begin
            check("spi byte", b, exp_bytes.pop_front());
          end
        end
      end
    end else begin
      high_cnt[id]++;
    end
    prev_sck[id] = sck;
    prev_ss3[id] = ss3;
    prev_di[id]  = di;
  endtask

  always @(negedge clk) begin
    mon_step(0, sck_a, ss3_a, di_a);
    mon_step(1, sck_b, ss3_b, di_b);
  end

  function automatic logic rdy(input int sel);
    return (sel == 0) ? cmd_ready_a : cmd_ready_b;
  endfunction

  function automatic logic bsy(input int sel);
    return (sel == 0) ? busy_a : busy_b;
  endfunction

  task automatic drive(input int sel, input logic v, input logic [1:0] t, input logic [2:0] l);
    if (sel == 0) begin cmd_valid_a = v; cmd_type_a = t; cmd_line_a = l; end
    else          begin cmd_valid_b = v; cmd_type_b = t; cmd_line_b = l; end
  endtask

  // Offer a command and return just after the accepting edge.
  task automatic send(input int sel, input logic [1:0] t, input logic [2:0] l, input bit keep);
    int n;
    @(negedge clk);
    drive(sel, 1'b1, t, l);
    n = 0;
    while (!rdy(sel) && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    check("accept within bound", int'(n < LIMIT), 1);
    @(posedge clk);
    #1;
    if (!keep) drive(sel, 1'b0, t, l);
  endtask

  task automatic wait_idle(input int sel);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((bsy(sel) || !rdy(sel)) && n < LIMIT);
    check("idle within bound", int'(n < LIMIT), 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, bad, base_f, base_r;
    for (int i = 0; i < 2048; i++) rxbuf[i] = 8'h00;
    reset_a = 1'b1; reset_b = 1'b1;
    drive(0, 1'b0, 2'd0, 3'd0);
    drive(1, 1'b0, 2'd0, 3'd0);

    // Reset state.
    @(negedge clk);
    check("reset ss3", ss3_a, 1);
    check("reset sck", sck_a, 0);
    check("reset di", di_a, 0);
    check("reset busy", busy_a, 0);
    check("reset done", done_a, 0);
    check("reset rd_addr", rd_addr_a, 0);
    check("reset cmd_ready", cmd_ready_a, 0);
    @(negedge clk);
    reset_a = 1'b0; reset_b = 1'b0;
    @(negedge clk);
    check("ready after reset", cmd_ready_a, 1);
    check("ready after reset b", cmd_ready_b, 1);

    // Enable: one 0x41 frame, 68 cycles of select low.
    exp_bytes.push_back(8'h41);
    push_frame(1, 0, 8, 68);
    send(0, 2'd1, 3'd0, 1'b0);
    n = 0;
    do begin @(negedge clk); n++; end while (!done_a && n < 1000);
    check("enable done seen", done_a, 1);
    check("busy at done", busy_a, 1);
    check("ss3 at done", ss3_a, 1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) check("done width", done_a, 0);
    end while (!cmd_ready_a && n < 100);
    check("ready delay after done", n, 8);
    check("osd enabled", osd_en[0], 1);

    // Disable then enable with cmd_valid held high.
    exp_bytes.push_back(8'h40);
    push_frame(1, 0, 8, 68);
    exp_bytes.push_back(8'h41);
    push_frame(1, 0, 8, 68);
    send(0, 2'd0, 3'd0, 1'b1);
    send(0, 2'd1, 3'd0, 1'b0);
    wait_idle(0);
    check("gap between frames >= 8", int'(last_gap[0] >= 8), 1);
    check("osd enabled after pair", osd_en[0], 1);

    // Type 3: done pulse only, no SPI activity.
    base_f = frames[0];
    base_r = total_rises[0];
    send(0, 2'd3, 3'd0, 1'b0);
    @(negedge clk);
    check("type3 done", done_a, 1);
    check("type3 busy", busy_a, 0);
    check("type3 ss3", ss3_a, 1);
    @(negedge clk);
    check("type3 done width", done_a, 0);
    repeat (10) @(negedge clk);
    check("type3 no sck", total_rises[0], base_r);
    check("type3 no frame", frames[0], base_f);

    // A request offered mid-frame is dropped.
    base_f = frames[0];
    exp_bytes.push_back(8'h41);
    push_frame(1, 0, 8, 68);
    send(0, 2'd1, 3'd0, 1'b0);
    repeat (20) @(negedge clk);
    drive(0, 1'b1, 2'd0, 3'd0);
    repeat (5) @(negedge clk);
    drive(0, 1'b0, 2'd0, 3'd0);
    wait_idle(0);
    repeat (30) @(negedge clk);
    check("busy request dropped", frames[0], base_f + 1);
    check("osd still enabled", osd_en[0], 1);

    // Write line 5 with a 256-byte payload.
    exp_bytes.push_back(8'h25);
    for (int i = 0; i < 256; i++) exp_bytes.push_back(8'(i) ^ 8'hA5);
    push_frame(257, 0, 2056, 16452);
    send(0, 2'd2, 3'd5, 1'b0);
    wait_idle(0);
    check("rd_addr wrapped", rd_addr_a, 0);
    bad = 0;
    for (int i = 0; i < 256; i++) if (rxbuf[1280 + i] != (8'(i) ^ 8'hA5)) bad++;
    check("line 5 buffer mismatches", bad, 0);

    // Reset mid-payload abandons the frame without a clock edge.
    exp_bytes.push_back(8'h23);
    for (int i = 0; i < 100; i++) exp_bytes.push_back(8'(i) ^ 8'hA5);
    push_frame(101, 4, 812, 0);
    send(0, 2'd2, 3'd3, 1'b0);
    n = 0;
    while (!(nbytes[0] == 101 && nbits[0] == 4) && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    check("abort point reached", int'(n < LIMIT), 1);
    #2;
    reset_a = 1'b1;
    #1;
    check("async reset ss3", ss3_a, 1);
    check("async reset sck", sck_a, 0);
    check("async reset di", di_a, 0);
    check("async reset busy", busy_a, 0);
    check("async reset rd_addr", rd_addr_a, 0);
    check("async reset cmd_ready", cmd_ready_a, 0);
    repeat (3) @(negedge clk);
    reset_a = 1'b0;
    @(negedge clk);
    check("ready after abort reset", cmd_ready_a, 1);
    check("aborted line not written", rxbuf[768], 0);
    exp_bytes.push_back(8'h41);
    push_frame(1, 0, 8, 68);
    send(0, 2'd1, 3'd0, 1'b0);
    wait_idle(0);

    // CLK_DIV=1, LINE_BYTES=4, write line 7.
    exp_bytes.push_back(8'h27);
    for (int i = 0; i < 4; i++) exp_bytes.push_back(8'(i) ^ 8'hA5);
    push_frame(5, 0, 40, 81);
    send(1, 2'd2, 3'd7, 1'b0);
    wait_idle(1);
    check("b rd_addr end", rd_addr_b, 4);
    bad = 0;
    for (int i = 0; i < 4; i++) if (rxbuf[1792 + i] != (8'(i) ^ 8'hA5)) bad++;
    check("line 7 buffer mismatches", bad, 0);

    repeat (10) @(negedge clk);
    check("expected bytes drained", exp_bytes.size(), 0);
    check("expected frames drained", exp_frames.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
